lopd_norm_pipe: RTL and testbench

Pipelined, parametrised leading/trailing-one position detector with a normalising shifter and a valid/ready handshake on both sides. It is the successor to the combinational 24-bit leading-one position detector. It adds:
- a selectable trailing-one mode,
- a normalised-data output for mantissa alignment,
- a two-stage registered pipeline that supports backpressure.

It sits between the adder/subtractor result path and the exponent-adjust logic in the floating-point datapath.

---
 rtl/lopd_norm_pipe.sv | 117 +++++++++++
 tb/tb_lopd_norm_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lopd_norm_pipe.sv
// Two-stage leading/trailing-one position detector with normalising shifter and valid/ready flow control.
// Build option: define LOPD_NORM_OUT_EN to compile in the shifter; otherwise o_norm_data is tied to 0.
module lopd_norm_pipe #(
  parameter int unsigned SIZE_DATA = 24,
  parameter int unsigned SIZE_LOPD = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_mode,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_LOPD-1:0] o_one_position,
  output logic                 o_zero_flag,
  output logic [SIZE_LOPD-1:0] o_shift_amt,
  output logic [SIZE_DATA-1:0] o_norm_data
);

  localparam int unsigned MSB_IDX = SIZE_DATA - 1;

  logic                 r_s1_valid;
  logic [SIZE_DATA-1:0] r_s1_data;
  logic                 r_s1_mode;

  logic                 r_s2_valid;
  logic [SIZE_LOPD-1:0] r_s2_pos;
  logic                 r_s2_zero;
  logic [SIZE_LOPD-1:0] r_s2_shift;

  logic                 w_adv2;
  logic                 w_load1;
  logic [SIZE_LOPD-1:0] w_lead_pos;
  logic [SIZE_LOPD-1:0] w_trail_pos;
  logic                 w_zero;
  logic [SIZE_LOPD-1:0] w_pos;
  logic [SIZE_LOPD-1:0] w_shift;

  // Stage 2 takes a beat when empty or draining; stage 1 when empty or passing forward.
  assign w_adv2  = !r_s2_valid || i_ready;
  assign o_ready = !r_s1_valid || w_adv2;
  assign w_load1 = i_valid && o_ready;

  // Highest set bit wins in the ascending scan, lowest in the descending scan.
  always_comb begin
    w_lead_pos  = '0;
    w_trail_pos = '0;
    for (int i = 0; i < int'(SIZE_DATA); i++) begin
      if (r_s1_data[i]) w_lead_pos = SIZE_LOPD'(i);
    end
    for (int i = int'(SIZE_DATA) - 1; i >= 0; i--) begin
      if (r_s1_data[i]) w_trail_pos = SIZE_LOPD'(i);
    end
  end

  assign w_zero  = ~|r_s1_data;
  assign w_pos   = w_zero ? '0 : (r_s1_mode ? w_trail_pos : w_lead_pos);
  assign w_shift = w_zero ? '0 :
                   (r_s1_mode ? w_trail_pos : (SIZE_LOPD'(MSB_IDX) - w_lead_pos));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= 1'b0;
    end else if (o_ready) begin
      r_s1_valid <= i_valid;
      if (w_load1) begin
        r_s1_data <= i_data;
        r_s1_mode <= i_mode;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_pos   <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_shift <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_pos   <= w_pos;
        r_s2_zero  <= w_zero;
        r_s2_shift <= w_shift;
      end
    end
  end

`ifdef LOPD_NORM_OUT_EN
  logic [SIZE_DATA-1:0] w_norm;
  logic [SIZE_DATA-1:0] r_s2_norm;

  // Left-justify for leading mode, right-justify for trailing mode.
  assign w_norm = r_s1_mode ? (r_s1_data >> w_shift) : (r_s1_data << w_shift);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_norm <= '0;
    end else if (w_adv2 && r_s1_valid) begin
      r_s2_norm <= w_norm;
    end
  end

  assign o_norm_data = r_s2_norm;
`else
  assign o_norm_data = '0;
`endif

  assign o_valid        = r_s2_valid;
  assign o_one_position = r_s2_pos;
  assign o_zero_flag    = r_s2_zero;
  assign o_shift_amt    = r_s2_shift;

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// Scoreboard bench for lopd_norm_pipe; expected beats are queued on acceptance, actual beats on output transfer.
module tb_lopd_norm_pipe;

  localparam int unsigned SD = 24;
  localparam int unsigned SL = 5;

  typedef struct packed {
    logic [SL-1:0] pos;
    logic          zf;
    logic [SL-1:0] sh;
    logic [SD-1:0] norm;
  } res_t;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [SD-1:0] i_data;
  logic          i_mode;
  logic          o_valid;
  logic          i_ready;
  logic [SL-1:0] o_one_position;
  logic          o_zero_flag;
  logic [SL-1:0] o_shift_amt;
  logic [SD-1:0] o_norm_data;

  res_t q_exp[$];
  res_t q_out[$];
  int   checks;
  int   failures;
  int   n_in;
  int   n_out;

  lopd_norm_pipe #(.SIZE_DATA(SD), .SIZE_LOPD(SL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
    .o_one_position(o_one_position), .o_zero_flag(o_zero_flag),
    .o_shift_amt(o_shift_amt), .o_norm_data(o_norm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: normalise by repeated single-bit shifts and count them.
  function automatic res_t model(input logic [SD-1:0] d, input logic m);
    res_t          r;
    logic [SD-1:0] x;
    int            n;
    r = '0;
    if (d == '0) begin
      r.zf = 1'b1;
      return r;
    end
    x = d;
    n = 0;
    if (!m) begin
      while (x[SD-1] == 1'b0) begin x = x << 1; n++; end
      r.pos = SL'(int'(SD) - 1 - n);
    end else begin
      while (x[0] == 1'b0) begin x = x >> 1; n++; end
      r.pos = SL'(n);
    end
    r.sh   = SL'(n);
    r.norm = x;
`ifndef LOPD_NORM_OUT_EN
    r.norm = '0;
`endif
    return r;
  endfunction

  function automatic res_t cur_out();
    return {o_one_position, o_zero_flag, o_shift_amt, o_norm_data};
  endfunction

  // One clock: drive at posedge+1, sample just before the next posedge.
  task automatic cycle(input logic v, input logic [SD-1:0] d, input logic m,
                       input logic rdy, output logic acc);
    i_valid = v; i_data = d; i_mode = m; i_ready = rdy;
    #3;
    acc = v && o_ready;
    if (acc) n_in++;
    if (o_valid && i_ready) begin
      q_out.push_back(cur_out());
      n_out++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && q_out.size() < q_exp.size(); i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_valid = 1'b0; i_data = '0; i_mode = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (cur_out() !== res_t'('0)) begin failures++; $display("FAIL reset_outs got=%h exp=0", cur_out()); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_walking_one();
    logic acc;
    res_t e, a;
    for (int k = 0; k < int'(SD); k++) begin
      cycle(1'b1, SD'(1) << k, 1'b0, 1'b1, acc);
      if (acc) begin
        e.pos = SL'(k); e.zf = 1'b0; e.sh = SL'(23 - k);
`ifdef LOPD_NORM_OUT_EN
        e.norm = 24'h800000;
`else
        e.norm = '0;
`endif
        q_exp.push_back(e);
      end
    end
    checks++; if (q_exp.size() != 24) begin failures++; $display("FAIL walk_accept got=%0d exp=24", q_exp.size()); end
    drain();
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_out.size() == 0) begin failures++; $display("FAIL walk_missing exp=%h", e); end
      else begin
        a = q_out.pop_front();
        if (a !== e) begin failures++; $display("FAIL walk got=%h exp=%h", a, e); end
      end
    end
  endtask

  task automatic test_zero_and_trailing();
    logic acc;
    res_t e, a;
    logic [SD-1:0] dv [4] = '{24'h000000, 24'h000000, 24'hA00000, 24'hA00000};
    logic          mv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    res_t          ev [4];
    ev[0] = {5'd0, 1'b1, 5'd0, 24'h000000};
    ev[1] = {5'd0, 1'b1, 5'd0, 24'h000000};
    ev[2] = {5'd21, 1'b0, 5'd21, 24'h000005};
    ev[3] = {5'd23, 1'b0, 5'd0, 24'hA00000};
`ifndef LOPD_NORM_OUT_EN
    for (int i = 0; i < 4; i++) ev[i].norm = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, dv[i], mv[i], 1'b1, acc);
      if (acc) q_exp.push_back(ev[i]);
    end
    drain();
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_out.size() == 0) begin failures++; $display("FAIL dir_missing exp=%h", e); end
      else begin
        a = q_out.pop_front();
        if (a !== e) begin failures++; $display("FAIL dir got=%h exp=%h", a, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    res_t e, a, snap;
    cycle(1'b1, 24'h000010, 1'b0, 1'b0, acc);
    if (acc) q_exp.push_back(model(24'h000010, 1'b0));
    cycle(1'b1, 24'h000100, 1'b0, 1'b0, acc);
    if (acc) q_exp.push_back(model(24'h000100, 1'b0));
    checks++; if (q_exp.size() != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", q_exp.size()); end
    cycle(1'b1, 24'h001000, 1'b0, 1'b0, acc);
    checks++; if (acc !== 1'b0) begin failures++; $display("FAIL bp_third_blocked got=%b exp=0", acc); end
    snap = cur_out();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", o_valid); end
    cycle(1'b1, 24'h001000, 1'b0, 1'b0, acc);
    cycle(1'b1, 24'h001000, 1'b0, 1'b0, acc);
    checks++; if (cur_out() !== snap) begin failures++; $display("FAIL bp_hold got=%h exp=%h", cur_out(), snap); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", o_ready); end
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) begin
      cycle(1'b1, 24'h001000, 1'b0, 1'b1, acc);
      if (acc) q_exp.push_back(model(24'h001000, 1'b0));
    end
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL bp_third_accept got=%b exp=1", acc); end
    drain();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_exp.size() == 0 || q_out.size() == 0) begin
        failures++; $display("FAIL bp_order_missing idx=%0d exp_pos=%0d", i, 4 * (i + 1));
      end else begin
        e = q_exp.pop_front();
        a = q_out.pop_front();
        if (a !== e || a.pos !== SL'(4 * (i + 1))) begin
          failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, a, e);
        end
      end
    end
  endtask

  task automatic test_random();
    logic acc;
    logic [SD-1:0] d;
    logic m;
    res_t e, a;
    int acc_cnt, in0, out0;
    acc_cnt = 0; in0 = n_in; out0 = n_out;
    for (int c = 0; c < 6000 && acc_cnt < 1000; c++) begin
      d = SD'($urandom);
      if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(0, 23);
      if ($urandom_range(0, 15) == 0) d = '0;
      m = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 3) != 0), d, m, 1'($urandom_range(0, 3) != 0), acc);
      if (acc) begin q_exp.push_back(model(d, m)); acc_cnt++; end
    end
    drain();
    checks++; if (acc_cnt != 1000) begin failures++; $display("FAIL rnd_accepted got=%0d exp=1000", acc_cnt); end
    checks++;
    if ((n_out - out0) != (n_in - in0)) begin
      failures++; $display("FAIL rnd_counts out=%0d in=%0d", n_out - out0, n_in - in0);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_out.size() == 0) begin failures++; $display("FAIL rnd_missing exp=%h", e); end
      else begin
        a = q_out.pop_front();
        if (a !== e) begin failures++; $display("FAIL rnd got=%h exp=%h", a, e); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic acc;
    res_t e, a;
    cycle(1'b1, 24'h000010, 1'b0, 1'b0, acc);
    cycle(1'b1, 24'h000300, 1'b1, 1'b0, acc);
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b exp=1", o_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL mid_async_ready got=%b exp=1", o_ready); end
    q_exp.delete();
    q_out.delete();
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 24'h000400, 1'b1, 1'b1, acc);
    if (acc) q_exp.push_back(model(24'h000400, 1'b1));
    cycle(1'b1, 24'h0F0000, 1'b0, 1'b1, acc);
    if (acc) q_exp.push_back(model(24'h0F0000, 1'b0));
    drain();
    checks++;
    if (q_out.size() == 0) begin failures++; $display("FAIL mid_first_missing exp_pos=10"); end
    else begin
      a = q_out.pop_front();
      e = q_exp.pop_front();
      if (a !== e || a.pos !== SL'(10)) begin failures++; $display("FAIL mid_first got=%h exp=%h", a, e); end
    end
    checks++;
    if (q_out.size() != 1 || q_exp.size() != 1) begin
      failures++; $display("FAIL mid_count got=%0d exp=1", q_out.size());
    end else begin
      a = q_out.pop_front();
      e = q_exp.pop_front();
      if (a !== e) begin failures++; $display("FAIL mid_second got=%h exp=%h", a, e); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; n_in = 0; n_out = 0;
    test_reset();
    test_walking_one();
    test_zero_and_trailing();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
